waddr_wdata_channel: RTL and testbench

- AXI write-side master for the image-block engine; the write counterpart of the read-address channel that walks a w1 x h1 block grid.
- Issues one AW burst per block with a fixed 3-beat burst (awlen=2) at a fixed 384-byte stride from dest_address.
- Streams result beats from the local pipeline onto W.
- Counts B responses and pulses done when every block is acknowledged.

---
 rtl/waddr_wdata_channel.sv | 173 +++++++++++++++++
 tb/tb_waddr_wdata_channel.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/waddr_wdata_channel.sv
// AXI write-side master for the image-block engine.
// Walks a (w1+1) x (h1+1) block grid, issuing one fixed-length AW burst per
// block at a fixed stride from the job base address. Result beats from the
// local pipeline are streamed onto W. B responses are counted, and done pulses
// once every block has been acknowledged.
module waddr_wdata_channel #(
  parameter int DATA_W    = 1024,
  parameter int BURST_LEN = 2,
  parameter int STRIDE    = 384,
  parameter int MAX_OUTST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [63:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic                  start_pulse,
  input  logic [63:0]           dest_address,
  input  logic [9:0]            w1,
  input  logic [9:0]            h1,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  bresp_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_AW     = 3'd1;
  localparam logic [2:0] S_W      = 3'd2;
  localparam logic [2:0] S_WAIT_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Wide enough to hold the value MAX_OUTST itself, not just MAX_OUTST-1.
  localparam int OW = $clog2(MAX_OUTST) + 1;

  logic [2:0]    state_q, state_d;
  logic [63:0]   addr_q, addr_d;       // address of the next burst to issue
  logic [19:0]   n_q, n_d;             // total blocks in this job
  logic [19:0]   issued_q, issued_d;   // AW handshakes so far
  logic [19:0]   acked_q, acked_d;     // counted B handshakes so far
  logic [OW-1:0] outst_q, outst_d;     // bursts issued but not yet acknowledged
  logic [7:0]    beat_q, beat_d;       // W beat index inside the current burst
  logic          err_q, err_d;

  logic [19:0] cols, rows;
  logic        st_aw, st_w, outst_full, last_beat;
  logic        aw_valid, aw_hs, w_valid, w_hs, b_hs, b_counted;

  // Decode the current state and the three channel handshakes.
  always_comb begin
    cols       = 20'(w1) + 20'd1;
    rows       = 20'(h1) + 20'd1;
    st_aw      = (state_q == S_AW);
    st_w       = (state_q == S_W);
    outst_full = (outst_q == OW'(MAX_OUTST));
    last_beat  = (beat_q == 8'(BURST_LEN));
    aw_valid   = st_aw && !outst_full;
    aw_hs      = aw_valid && m_axi_awready;
    w_valid    = st_w && s_valid;
    w_hs       = w_valid && m_axi_wready;
    b_hs       = (state_q != S_IDLE) && m_axi_bvalid;
    b_counted  = b_hs && (outst_q != '0);
  end

  // Next-state logic: job sequencing plus the outstanding/ack bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    n_d      = n_q;
    issued_d = issued_q;
    acked_d  = acked_q;
    outst_d  = outst_q;
    beat_d   = beat_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_d  = S_AW;
          addr_d   = dest_address;
          n_d      = cols * rows;    // 1024 x 1024 wraps to 0, which still terminates after 2^20 blocks
          issued_d = '0;
          acked_d  = '0;
          outst_d  = '0;
          beat_d   = '0;
          err_d    = 1'b0;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          state_d  = S_W;
          beat_d   = '0;
          addr_d   = addr_q + 64'(STRIDE);
          issued_d = issued_q + 20'd1;
        end
      end
      S_W: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = (issued_q == n_q) ? S_WAIT_B : S_AW;
        end
      end
      S_WAIT_B: begin
        if (acked_q == n_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // B handshakes only happen while busy, so these never collide with the
    // clears done on start in IDLE.
    case ({aw_hs, b_counted})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: ;
    endcase
    if (b_counted) acked_d = acked_q + 20'd1;
    if (b_hs && ((m_axi_bresp != 2'b00) || (outst_q == '0))) err_d = 1'b1;
  end

  // State registers with synchronous reset; a reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= S_IDLE;
      addr_q   <= '0;
      n_q      <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      outst_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      acked_q  <= acked_d;
      outst_q  <= outst_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Output drive: everything is gated by state so reset and IDLE present zeros.
  always_comb begin
    m_axi_awvalid = aw_valid;
    m_axi_awaddr  = aw_valid ? addr_q : '0;
    m_axi_awlen   = aw_valid ? 8'(BURST_LEN) : '0;
    m_axi_wvalid  = w_valid;
    m_axi_wdata   = st_w ? s_data : '0;
    m_axi_wstrb   = w_valid ? '1 : '0;
    m_axi_wlast   = st_w && last_beat;
    m_axi_bready  = (state_q != S_IDLE);
    s_ready       = st_w && m_axi_wready;
    busy          = (state_q != S_IDLE);
    done_pulse    = (state_q == S_DONE);
    bresp_err     = err_q;
  end

endmodule

// File: tb/tb_waddr_wdata_channel.sv
// Self-checking bench for waddr_wdata_channel: directed jobs with random
// payloads and optional random handshakes, checked against per-job expected
// address lists and beat sequences computed from the block-grid rules.
module tb_waddr_wdata_channel;

  localparam int DW = 1024;
  typedef logic [DW-1:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [63:0]     m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic            m_axi_awvalid;
  logic            m_axi_awready = 1'b1;
  beat_t           m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready = 1'b1;
  logic [1:0]      m_axi_bresp = 2'b00;
  logic            m_axi_bvalid = 1'b0;
  logic            m_axi_bready;
  logic            start_pulse = 1'b0;
  logic [63:0]     dest_address = '0;
  logic [9:0]      w1 = '0;
  logic [9:0]      h1 = '0;
  beat_t           s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic            busy;
  logic            done_pulse;
  logic            bresp_err;

  waddr_wdata_channel #(.DATA_W(DW), .BURST_LEN(2), .STRIDE(384), .MAX_OUTST(8)) dut (
    .clk(clk), .rst(rst),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .start_pulse(start_pulse), .dest_address(dest_address), .w1(w1), .h1(h1),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done_pulse(done_pulse), .bresp_err(bresp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the current job.
  beat_t       src_q[$], exp_d_q[$], w_obs_q[$];
  bit          wl_q[$];
  logic [63:0] exp_a_q[$], aw_obs_q[$];
  int          bpend, b_idx, done_cnt, aw_hold;
  int          b_credit   = -1;  // -1: unlimited B responses
  int          err_block  = -1;  // block index that gets SLVERR
  bit          exp_err, rand_mode;
  int          awlen_bad, overlap_bad, w_early_bad, aw_unstable, strb_bad, busy_bad;
  bit          prev_aw_wait;
  logic [63:0] prev_awaddr;
  bit          smp_busy, smp_done, smp_awvalid, smp_err, smp_any;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rnd_beat();
    beat_t v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: sample everything on the falling edge, drive bench-side
  // handshake partners just after the rising edge.
  task automatic cycle();
    bit aw_hs, w_hs, b_hs, s_hs;
    @(negedge clk);
    aw_hs = m_axi_awvalid && m_axi_awready;
    w_hs  = m_axi_wvalid && m_axi_wready;
    b_hs  = m_axi_bvalid && m_axi_bready;
    s_hs  = s_valid && s_ready;
    if (aw_hs) begin
      aw_obs_q.push_back(m_axi_awaddr);
      if (m_axi_awlen != 8'd2) awlen_bad++;
      bpend++;
    end
    if (m_axi_awvalid && m_axi_wvalid) overlap_bad++;
    if (w_hs) begin
      w_obs_q.push_back(m_axi_wdata);
      wl_q.push_back(m_axi_wlast);
      if (m_axi_wstrb != '1) strb_bad++;
      if (w_obs_q.size() > 3 * aw_obs_q.size()) w_early_bad++;
    end
    if (prev_aw_wait && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) aw_unstable++;
    prev_aw_wait = m_axi_awvalid && !m_axi_awready;
    prev_awaddr  = m_axi_awaddr;
    if (done_pulse) done_cnt++;
    smp_busy    = busy;
    smp_done    = done_pulse;
    smp_awvalid = m_axi_awvalid;
    smp_err     = bresp_err;
    smp_any     = |{m_axi_awaddr, m_axi_awlen, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
                    m_axi_wlast, m_axi_wvalid, m_axi_bready, s_ready, busy, done_pulse, bresp_err};

    @(posedge clk);
    #1;
    start_pulse = 1'b0;
    if (s_hs) void'(src_q.pop_front());
    if (!(s_valid && !s_hs))
      s_valid = (src_q.size() > 0) && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
    s_data = (src_q.size() > 0) ? src_q[0] : '0;
    m_axi_wready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (aw_hold > 0) begin
      m_axi_awready = 1'b0;
      aw_hold--;
    end else begin
      m_axi_awready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    if (b_hs) begin
      bpend--;
      b_idx++;
      if (b_credit > 0) b_credit--;
    end
    m_axi_bvalid = (bpend > 0) && (b_credit != 0);
    m_axi_bresp  = (b_idx == err_block) ? 2'b10 : 2'b00;
  endtask

  // Build the expected job from the grid rules and pulse start.
  task automatic start_job(input logic [63:0] dest, input int w1v, input int h1v, input int errblk);
    int n;
    n = (w1v + 1) * (h1v + 1);
    exp_a_q.delete(); aw_obs_q.delete(); exp_d_q.delete(); w_obs_q.delete();
    wl_q.delete(); src_q.delete();
    for (int y = 0; y <= h1v; y++)
      for (int x = 0; x <= w1v; x++)
        exp_a_q.push_back(dest + 64'(y * (w1v + 1) + x) * 64'd384);
    for (int i = 0; i < 3 * n; i++) begin
      beat_t b;
      b = rnd_beat();
      src_q.push_back(b);
      exp_d_q.push_back(b);
    end
    awlen_bad = 0; overlap_bad = 0; w_early_bad = 0; aw_unstable = 0;
    strb_bad = 0; busy_bad = 0; done_cnt = 0; b_idx = 0;
    err_block = errblk;
    exp_err = (errblk >= 0) && (errblk < n);
    dest_address = dest;
    w1 = 10'(w1v);
    h1 = 10'(h1v);
    start_pulse = 1'b1;
    cycle();
    cycle();
    check("busy_after_start", 64'(smp_busy), 64'd1);
    check("err_cleared_at_start", 64'(smp_err), 64'd0);
  endtask

  // Run to completion and compare everything observed against the model.
  task automatic wait_done(input bit dup_start);
    bit got;
    int mism;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      cycle();
      if (!smp_busy) busy_bad++;
      got = smp_done;
      if (dup_start && i == 5) begin
        start_pulse  = 1'b1;
        dest_address = 64'hdead_0000;
        w1           = 10'd7;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    cycle();
    check("busy_drop_after_done", 64'(smp_busy), 64'd0);
    repeat (3) cycle();
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_span", 64'(busy_bad), 64'd0);
    check("aw_count", 64'(aw_obs_q.size()), 64'(exp_a_q.size()));
    mism = 0;
    for (int i = 0; i < aw_obs_q.size() && i < exp_a_q.size(); i++)
      if (aw_obs_q[i] !== exp_a_q[i]) mism++;
    check("aw_addr_mismatches", 64'(mism), 64'd0);
    check("awlen_bad", 64'(awlen_bad), 64'd0);
    check("w_count", 64'(w_obs_q.size()), 64'(exp_d_q.size()));
    mism = 0;
    for (int i = 0; i < w_obs_q.size() && i < exp_d_q.size(); i++)
      if (w_obs_q[i] !== exp_d_q[i]) mism++;
    check("wdata_mismatches", 64'(mism), 64'd0);
    mism = 0;
    for (int i = 0; i < wl_q.size(); i++)
      if (wl_q[i] != ((i % 3) == 2)) mism++;
    check("wlast_mismatches", 64'(mism), 64'd0);
    check("wstrb_bad", 64'(strb_bad), 64'd0);
    check("aw_w_overlap", 64'(overlap_bad), 64'd0);
    check("w_before_aw", 64'(w_early_bad), 64'd0);
    check("aw_unstable", 64'(aw_unstable), 64'd0);
    check("bresp_err_final", 64'(smp_err), 64'(exp_err));
  endtask

  initial begin
    repeat (2) cycle();
    check("reset_outputs_zero", 64'(smp_any), 64'd0);
    rst = 1'b0;
    repeat (2) cycle();
    check("idle_not_busy", 64'(smp_busy), 64'd0);

    // Single block.
    start_job(64'h1000, 0, 0, -1);
    wait_done(1'b0);

    // 3x2 grid, plus a start pulse while busy that must be ignored.
    start_job(64'h0, 2, 1, -1);
    wait_done(1'b1);

    // awready held low across the first AW.
    aw_hold = 12;
    start_job(64'h4000, 1, 0, -1);
    wait_done(1'b0);

    // Random s_valid / wready / awready.
    rand_mode = 1'b1;
    start_job(64'h1_0000, 3, 2, -1);
    wait_done(1'b0);
    rand_mode = 1'b0;

    // SLVERR on block 1: sticky error, job still completes.
    start_job(64'h8000, 1, 0, 1);
    wait_done(1'b0);

    // Next start clears the error; addresses wrap past 2^64.
    start_job(64'hffff_ffff_ffff_fe80, 1, 0, -1);
    wait_done(1'b0);

    // Outstanding limit: withhold B, expect exactly 8 AWs.
    b_credit = 0;
    start_job(64'h2000, 15, 0, -1);
    repeat (150) cycle();
    check("outst_limit_aw_count", 64'(aw_obs_q.size()), 64'd8);
    check("outst_limit_awvalid_low", 64'(smp_awvalid), 64'd0);
    b_credit = 1;
    repeat (20) cycle();
    check("one_b_frees_one_aw", 64'(aw_obs_q.size()), 64'd9);
    b_credit = -1;
    wait_done(1'b0);

    // Reset in the middle of a job.
    start_job(64'h5000, 3, 1, -1);
    for (int i = 0; i < 200 && w_obs_q.size() < 4; i++) cycle();
    check("reached_mid_job", 64'(w_obs_q.size() >= 4), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_mid_job_outputs_zero", 64'(smp_any), 64'd0);
    src_q.delete();
    bpend = 0;
    s_valid = 1'b0;
    m_axi_bvalid = 1'b0;
    repeat (20) cycle();
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    check("idle_after_reset", 64'(smp_busy), 64'd0);

    // Recovery job after reset.
    start_job(64'h3000, 0, 1, -1);
    wait_done(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
